// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the decode stage and control unit.
package imm_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned SHAMT_W  = 6;

  // Immediate-type select driven by the control unit
  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_U   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_J   = 3'd4,
    IMM_SH  = 3'd5,
    IMM_Z   = 3'd6,
    IMM_RSV = 3'd7
  } immsrc_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
//  instr   : 32-bit instruction word (opcode bits [6:0] not used)
//  immsrc  : immediate format select
//  imm     : XLEN-wide decoded immediate
//  illegal : select was the reserved encoding
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  input  immsrc_e            immsrc,
  output logic [XLEN-1:0]    imm,
  output logic               illegal
);

  logic [31:0]        raw32;
  logic [SHAMT_W-1:0] shamt;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // RV64 shifts take a 6-bit shamt, RV32 only 5
  assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Signed formats are built as 32-bit values, then sign-extended to 64 and
  // truncated to XLEN, which keeps one code path for both widths.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    raw32   = '0;
    case (immsrc)
      IMM_I: begin
        raw32 = {{20{instr[31]}}, instr[31:20]};
        imm   = XLEN'({{32{raw32[31]}}, raw32});
      end
      IMM_U: begin
        raw32 = {instr[31:12], 12'b0};
        imm   = XLEN'({{32{raw32[31]}}, raw32});
      end
      IMM_S: begin
        raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm   = XLEN'({{32{raw32[31]}}, raw32});
      end
      IMM_B: begin
        raw32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm   = XLEN'({{32{raw32[31]}}, raw32});
      end
      IMM_J: begin
        raw32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm   = XLEN'({{32{raw32[31]}}, raw32});
      end
      IMM_SH:  imm = XLEN'(shamt);
      IMM_Z:   imm = XLEN'(instr[19:15]);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, optional
// 2-entry skid buffer and synchronous flush.
//  clk, rst_n            : clock, async active-low reset
//  flush                 : drop every held entry at the next edge
//  in_valid/in_ready     : upstream handshake, instr + immsrc payload
//  out_valid/out_ready   : downstream handshake, immop + imm_illegal payload
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter bit          SKID = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  immsrc_e            immsrc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    immop,
  output logic               imm_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  logic            m_valid_q, m_valid_d, m_ill_q, m_ill_d;
  logic [XLEN-1:0] m_imm_q, m_imm_d;
  logic            s_valid_q, s_valid_d, s_ill_q, s_ill_d;
  logic [XLEN-1:0] s_imm_q, s_imm_d;
  logic            accept, consume;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .immsrc  (immsrc),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  // Skid mode: ready depends only on the skid register, no path from out_ready
  assign in_ready = SKID ? !s_valid_q : (!m_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid_q && out_ready;

  // Next-state for main (M) and skid (S) entries
  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_ill_d   = m_ill_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_ill_d   = s_ill_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (SKID && s_valid_q) begin
      // in_ready is low here, so only a promotion S -> M can happen
      if (consume) begin
        m_imm_d   = s_imm_q;
        m_ill_d   = s_ill_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q && !consume) begin
      // M held: a new word parks in S (reachable only with the skid buffer)
      if (accept) begin
        s_valid_d = 1'b1;
        s_imm_d   = dec_imm;
        s_ill_d   = dec_ill;
      end
    end else begin
      // M empty or draining this cycle: new word goes straight to M
      m_valid_d = accept;
      if (accept) begin
        m_imm_d = dec_imm;
        m_ill_d = dec_ill;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_ill_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_ill_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_ill_q   <= m_ill_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_ill_q   <= s_ill_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign immop       = m_imm_q;
  assign imm_illegal = m_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 skid instances share one
// scoreboard, a SKID=0 instance keeps its own.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  immsrc_e     immsrc = IMM_I;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_immop;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_immop;
  logic        z_in_ready, z_out_valid, z_ill;
  logic [31:0] z_immop;

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t q0[$];
  exp_t cur;
  logic acc_a;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .immsrc(immsrc), .out_valid(a_out_valid), .out_ready(out_ready),
    .immop(a_immop), .imm_illegal(a_ill));

  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .immsrc(immsrc), .out_valid(b_out_valid), .out_ready(out_ready),
    .immop(b_immop), .imm_illegal(b_ill));

  imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .instr(instr), .immsrc(immsrc), .out_valid(z_out_valid), .out_ready(out_ready),
    .immop(z_immop), .imm_illegal(z_ill));

  // Reference decode, written straight from the format table
  function automatic exp_t model(input logic [31:0] i, input immsrc_e s);
    exp_t        e;
    logic [63:0] r;
    r     = '0;
    e.ill = 1'b0;
    case (s)
      IMM_I:  r = {{52{i[31]}}, i[31:20]};
      IMM_U:  r = {{32{i[31]}}, i[31:12], 12'b0};
      IMM_S:  r = {{52{i[31]}}, i[31:25], i[11:7]};
      IMM_B:  r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:  r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_SH: r = {58'b0, i[25:20]};
      IMM_Z:  r = {59'b0, i[19:15]};
      default: e.ill = 1'b1;
    endcase
    e.e64 = r;
    e.e32 = (s == IMM_SH) ? {27'b0, i[24:20]} : r[31:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input immsrc_e s);
    instr    = i;
    immsrc   = s;
    in_valid = 1'b1;
    cur      = model(i, s);
  endtask

  // Directed vector with hand-derived expectations
  task automatic drive_k(input logic [31:0] i, input immsrc_e s,
                         input logic [31:0] e32, input logic [63:0] e64, input logic ill);
    instr    = i;
    immsrc   = s;
    in_valid = 1'b1;
    cur.e32  = e32;
    cur.e64  = e64;
    cur.ill  = ill;
  endtask

  // Called just after a negedge with inputs set; checks, updates scoreboards,
  // and returns at the following negedge.
  task automatic tick();
    #1;
    chk("a_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    chk("b_valid", 64'(b_out_valid), 64'(qa.size() != 0));
    chk("a_ready", 64'(a_in_ready), 64'(qa.size() < 2));
    chk("b_ready", 64'(b_in_ready), 64'(qa.size() < 2));
    if (qa.size() != 0) begin
      chk("a_imm", 64'(a_immop), 64'(qa[0].e32));
      chk("a_ill", 64'(a_ill), 64'(qa[0].ill));
      chk("b_imm", b_immop, qa[0].e64);
      chk("b_ill", 64'(b_ill), 64'(qa[0].ill));
      if (out_ready) void'(qa.pop_front());
    end
    chk("z_valid", 64'(z_out_valid), 64'(q0.size() != 0));
    chk("z_ready", 64'(z_in_ready), 64'(q0.size() == 0 || out_ready));
    if (q0.size() != 0) begin
      chk("z_imm", 64'(z_immop), 64'(q0[0].e32));
      chk("z_ill", 64'(z_ill), 64'(q0[0].ill));
    end
    acc_a = in_valid && a_in_ready && !flush;
    if (flush) begin
      qa.delete();
      q0.delete();
    end else begin
      if (in_valid && a_in_ready) qa.push_back(cur);
      if (q0.size() != 0 && out_ready) void'(q0.pop_front());
      if (in_valid && z_in_ready) q0.push_back(cur);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_imm", 64'(a_immop), 64'd0);
    chk("rst_b_imm", b_immop, 64'd0);
    chk("rst_b_ill", 64'(b_ill), 64'd0);
    chk("rst_a_ready", 64'(a_in_ready), 64'd1);
    chk("rst_z_ready", 64'(z_in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Decode table, back-to-back with downstream always ready
    out_ready = 1'b1;
    drive_k(32'hFFF00093, IMM_I,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0); tick();
    drive_k(32'h7FF00093, IMM_I,  32'h000007FF, 64'h00000000000007FF, 1'b0); tick();
    drive_k(32'h800000B7, IMM_U,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0); tick();
    drive_k(32'h123450B7, IMM_U,  32'h12345000, 64'h0000000012345000, 1'b0); tick();
    drive_k(32'hFE112E23, IMM_S,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0); tick();
    drive_k(32'hFE000EE3, IMM_B,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0); tick();
    drive_k(32'h0080006F, IMM_J,  32'h00000008, 64'h0000000000000008, 1'b0); tick();
    drive_k(32'h03F01013, IMM_SH, 32'h0000001F, 64'h000000000000003F, 1'b0); tick();
    drive_k(32'h000FD073, IMM_Z,  32'h0000001F, 64'h000000000000001F, 1'b0); tick();
    drive_k(32'hFFFFFFFF, IMM_RSV, 32'h0, 64'h0, 1'b1); tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: A, B fill M and S, C is refused until space frees
    out_ready = 1'b0;
    drive(32'h00100093, IMM_I); tick();
    drive(32'h00200093, IMM_I); tick();
    drive(32'h00300093, IMM_I); tick();
    chk("skid_c_refused", 64'(acc_a), 64'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 8 && in_valid; n++) begin
      tick();
      if (acc_a) in_valid = 1'b0;
    end
    chk("skid_c_taken", 64'(in_valid), 64'd0);
    in_valid = 1'b0;
    repeat (4) tick();

    // Flush with both entries full and an incoming word
    out_ready = 1'b0;
    drive(32'h00400093, IMM_I); tick();
    drive(32'h00500093, IMM_I); tick();
    drive(32'hDEAD00B7, IMM_U);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset while holding a word
    out_ready = 1'b0;
    drive(32'hABC00093, IMM_I); tick();
    in_valid = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 64'(a_out_valid), 64'd0);
    chk("arst_a_imm", 64'(a_immop), 64'd0);
    chk("arst_b_valid", 64'(b_out_valid), 64'd0);
    chk("arst_b_imm", b_immop, 64'd0);
    chk("arst_z_valid", 64'(z_out_valid), 64'd0);
    chk("arst_a_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0)
        drive($urandom, immsrc_e'(3'($urandom_range(0, 7))));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
